oneshot_deadtime_arbiter: RTL
=============================

Name: oneshot_deadtime_arbiter

Overview:
Round-robin arbiter that shares a single programmable-deadtime pulse resource between NSRC level-type requesters, e.g. per-VFAT trigger/S-bit activity lines feeding one downstream pulse consumer.
Each source is one-shot edge-qualified: one event per rising edge, re-armed only after the source returns low.
Accepted events queue as pending bits and are granted one at a time, with at least deadtime_i idle cycles between grants.
Sits between the cluster-building one-shot stage and the shared trigger/readout consumer.

Parameters:
NSRC, 8, number of requesting sources (2..32)
DTBITS, 4, width of deadtime_i
IDXBITS, 3, width of grant_idx_o; must equal ceil(log2(NSRC))

Ports:
clock  input  1  system clock, all logic on its rising edge
reset  input  1  synchronous, active-high reset
req_i  input  NSRC  level request per source
mask_i  input  NSRC  1 = source disabled
deadtime_i  input  DTBITS  idle cycles enforced after each grant
grant_o  output  1  one-cycle pulse, one event granted
grant_idx_o  output  IDXBITS  index of the granted source; valid when grant_o=1, holds last value otherwise
pending_o  output  NSRC  registered pending bits
busy_o  output  1  1 while in HOLD (deadtime running)
overflow_o  output  1  one-cycle pulse, event dropped

Behaviour:
- Reset values:
  - grant_o=0, grant_idx_o=0, pending_o=0, busy_o=0, overflow_o=0.
  - armed[]=all 1, so a source held high through reset fires once after reset.
  - rr_last=NSRC-1, so source 0 has first priority.
  - FSM state=IDLE, dead counter=0.
- Reset asserted mid-HOLD or with pending events discards everything; state returns to the reset values above on the next edge.
- Edge qualification, per source i:
  - edge[i] = req_i[i] & armed[i] & ~mask_i[i].
  - armed[i] is cleared on edge[i]. It is set again on the first cycle req_i[i]=0 is sampled.
  - A source held high generates exactly one event.
- Pending:
  - pending[i] is set on the edge after edge[i].
  - pending[i] is cleared when source i is granted.
  - mask_i[i]=1 clears pending[i] on the next edge.
  - Simultaneous grant-clear and new edge[i] on the same source: set wins; the new event stays pending.
  - edge[i] while pending[i]=1 and not being granted that cycle: event dropped, overflow_o pulses for 1 cycle. Multiple drops in one cycle give a single pulse.
- Round-robin selection: choose the first pending index searching upward from rr_last+1, wrapping at NSRC-1 -> 0. rr_last updates to the granted index.
- FSM states:
  - IDLE:
    - If pending != 0: grant_o=1 on the next edge, grant_idx_o=selected index, clear that pending bit, load dead counter with deadtime_i sampled this cycle.
    - If deadtime_i==0, stay IDLE; back-to-back grants are possible every cycle.
    - If deadtime_i!=0, go to HOLD.
  - HOLD: busy_o=1, grant_o=0, counter decrements each cycle. When counter==1, go to IDLE.
  - Result: the grant-to-grant spacing is deadtime_i+1 cycles, and deadtime_i must be stable only at grant time.
  - Illegal state: recover to IDLE.
- Latency: req_i rising sampled at edge k -> pending_o set after edge k -> grant_o high after edge k+1 (2 cycles) when IDLE and no higher-priority pending.
- Edge detection and pending capture continue during HOLD.
- All outputs are registered.

Optional Feature:
Macro ONESHOT_ARB_DROPCNT_EN.
- Defined:
  - Adds output port drop_cnt_o, 16 bits: saturating count of cycles with overflow_o=1.
  - Holds at 0xFFFF once saturated.
  - Reset to 0 by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then req_i=0x01 held high for 10 cycles, deadtime_i=3 -> exactly one grant_o with grant_idx_o=0, 2 cycles after the first sample; busy_o high 3 cycles; no second grant until req_i[0] falls and rises again.
- req_i=0xFF rising together, deadtime_i=0 -> 8 consecutive grants, idx 0,1,...,7; pending_o steps 0xFF->0x00; no overflow.
- deadtime_i=2, sources 3 and 5 pending -> grants exactly 3 cycles apart; order 3 then 5; after rr_last=5, a new pending on 3 and 6 grants 6 first.
- Source 2 pending, busy in HOLD (deadtime_i=7), source 2 toggles low/high -> overflow_o one pulse; only one grant for source 2 after HOLD; drop_cnt_o=1 with ONESHOT_ARB_DROPCNT_EN.
- Source 4 pending, then mask_i[4]=1 -> pending_o[4] clears next cycle, never granted; edges while masked are ignored with no overflow.
- reset asserted mid-HOLD with pending_o=0x0A -> next cycle all outputs at reset values; a held-high req_i[1] grants idx 1 after reset deasserts.

Source files
------------

// File: rtl/oneshot_deadtime_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : oneshot_deadtime_arbiter
// Description : Round-robin arbiter granting one-shot edge events from NSRC
//               level requesters to a single pulse consumer, with a
//               programmable number of idle cycles after every grant.
//               Optional macro ONESHOT_ARB_DROPCNT_EN adds the drop_cnt_o
//               saturating counter of overflow cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module oneshot_deadtime_arbiter #(
    parameter int NSRC    = 8,
    parameter int DTBITS  = 4,
    parameter int IDXBITS = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NSRC-1:0]    req_i,
    input  logic [NSRC-1:0]    mask_i,
    input  logic [DTBITS-1:0]  deadtime_i,
    output logic               grant_o,
    output logic [IDXBITS-1:0] grant_idx_o,
    output logic [NSRC-1:0]    pending_o,
    output logic               busy_o,
    output logic               overflow_o
`ifdef ONESHOT_ARB_DROPCNT_EN
    ,
    output logic [15:0]        drop_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01
    } state_t;

    localparam logic [NSRC-1:0] c_ONE = {{(NSRC-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [DTBITS-1:0]   cnt_q, cnt_d;
    logic [NSRC-1:0]     armed_q, armed_d;
    logic [NSRC-1:0]     pending_q, pending_d;
    logic [IDXBITS-1:0]  rr_last_q, rr_last_d;
    logic [IDXBITS-1:0]  idx_q, idx_d;
    logic                grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;

    logic [NSRC-1:0]     w_edge;
    logic [NSRC-1:0]     w_clr;
    logic [IDXBITS-1:0]  w_sel_idx;
    logic                w_found;

    // Edge qualification: a source re-arms on the first low sample.
    always_comb begin
        w_edge  = req_i & armed_q & ~mask_i;
        armed_d = ~req_i | (armed_q & ~w_edge);
    end

    // Round-robin search starting just above the last granted index.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        for (int k = 1; k <= NSRC; k++) begin
            int j;
            j = (int'(rr_last_q) + k) % NSRC;
            if (!w_found && pending_q[j]) begin
                w_found   = 1'b1;
                w_sel_idx = IDXBITS'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        idx_d     = idx_q;
        grant_d   = 1'b0;
        w_clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_d   = 1'b1;
                    idx_d     = w_sel_idx;
                    rr_last_d = w_sel_idx;
                    w_clr     = c_ONE << w_sel_idx;
                    cnt_d     = deadtime_i;
                    if (deadtime_i != '0) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= DTBITS'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new edge beats the grant-clear on the same source; mask beats both.
        pending_d = ((pending_q & ~w_clr) | w_edge) & ~mask_i;
        ovf_d     = |(w_edge & pending_q & ~w_clr);
        busy_d    = (state_d == ST_HOLD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            armed_q   <= '1;
            pending_q <= '0;
            rr_last_q <= IDXBITS'(NSRC - 1);
            idx_q     <= '0;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
            rr_last_q <= rr_last_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef ONESHOT_ARB_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign pending_o   = pending_q;
    assign busy_o      = busy_q;
    assign overflow_o  = ovf_q;

endmodule
`default_nettype wire
